dcache_wt: RTL
==============

# dcache_wt

Direct-mapped, write-through, one-word-per-line data cache between the M stage of the `mips` pipeline and a slow backing data memory. It consumes `memwriteM`, `aluoutM`, `writedataM` and a read strobe, and returns `readdataM`. It raises a stall while a backing-memory transaction is in flight. The backing-memory side uses a simple held-request / one-cycle-ack handshake.

## Interface
- `LINES`, default 16: number of lines; power of two, ≥2. `IDX_W = log2(LINES)`.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `cpu_rd` input 1: M-stage load strobe (memtoregM).
- `cpu_wr` input 1: M-stage store strobe (memwriteM).
- `cpu_addr` input 32: byte address (aluoutM); bits [1:0] ignored.
- `cpu_wdata` input 32: store data (writedataM).
- `cpu_rdata` output 32: load data (readdataM); valid when `cpu_rd & ~cpu_stall`.
- `cpu_stall` output 1: freeze pipeline; combinational.
- `mem_req` output 1: backing-memory request, registered.
- `mem_we` output 1: 1 = write, 0 = read; registered.
- `mem_addr` output 32: word-aligned address `{cpu_addr[31:2],2'b00}`; registered.
- `mem_wdata` output 32: store data; registered.
- `mem_ack` input 1: one-cycle completion pulse.
- `mem_rdata` input 32: read data, valid in the `mem_ack` cycle.
- `hit_cnt`, `miss_cnt` output 32 each: present only under `DCACHE_STATS_EN`.

## Operation
- Address split: index = `cpu_addr[IDX_W+1:2]`, tag = `cpu_addr[31:IDX_W+2]`. Per line there is a valid bit, a tag, and 32 data bits.
- Hit = `valid[index] & tag[index]==tag`.
- State machine:
  - IDLE:
    - `cpu_wr`: stall=1. Next: WRITE. Latch the mem_* outputs. If hit, update the line data in the same edge. On a write miss there is no allocate.
    - `cpu_rd & hit`: stall=0; `cpu_rdata` = line data (combinational).
    - `cpu_rd & ~hit`: stall=1. Next: FILL, with mem_we=0.
    - Neither strobe: stall=0.
    - If both strobes are set, the write wins.
  - FILL: stall=1; mem_req held. On `mem_ack`: write `mem_rdata` and the tag into the line, set valid, go to IDLE. The CPU still presents the load, which then hits.
  - WRITE: stall=1; mem_req held. On `mem_ack`, go to WDONE.
  - WDONE: stall=0 for exactly one cycle so the store retires. Strobes are ignored; next state is IDLE.
- `mem_ack` outside FILL/WRITE is ignored.
- `cpu_rdata` = 0 when not (`cpu_rd` & IDLE & hit).

## Timing
- Reset values:
  - state IDLE; all valid bits 0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `cpu_stall`=0 (IDLE, no strobe); `cpu_rdata`=0.
  - Counters 0.
  - Tag and data arrays are not reset.
- Read hit: 0 extra cycles.
- Read miss: stall from the request cycle through the ack cycle, plus 1 hit cycle. Total stall = (cycles to ack) + 1.
- Store: stall from the request cycle through the ack cycle; WDONE follows the ack with stall=0.
- Handshake:
  - `mem_req` rises the cycle after the miss or store is detected.
  - `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_req`=1.
  - `mem_req` falls on the edge that samples `mem_ack`.
  - The slave acks at most once per request, and no earlier than the cycle after `mem_req` rises.
- Reset mid-transaction: the request is abandoned and `mem_req` drops asynchronously. A late ack is ignored. The line is not written.
- Stall rule: `cpu_stall` depends only on state, strobes and hit, with no path from `mem_ack`.

## Configuration
- `DCACHE_STATS_EN` defined:
  - `hit_cnt` increments on every IDLE cycle with `cpu_rd & ~cpu_wr & hit`. This includes the post-fill hit.
  - `miss_cnt` increments on every IDLE→FILL transition.
  - Counters wrap at 2^32 and are cleared by `rst`.
- Not defined: both ports and counters are absent, with no other behavioural difference.

## Test plan
- Reset, then read 0x100; slave acks 3 cycles after `mem_req` with 0xDEADBEEF → `mem_addr`=0x100 and `mem_we`=0; stall lasts 4 cycles; the next cycle `cpu_rdata`=0xDEADBEEF with stall=0. With stats: miss_cnt=1, hit_cnt=1.
- Repeat the read of 0x100 → stall=0, data 0xDEADBEEF, no `mem_req`.
- Store 0x12345678 to 0x100 (hit) → `mem_we`=1, `mem_wdata`=0x12345678. After the ack there is one WDONE cycle with stall=0. A subsequent read of 0x100 hits and returns 0x12345678.
- Store to 0x200 (miss; same index as 0x100 at LINES=16) → memory write only. A read of 0x200 then misses. A read of 0x100 after the refill of 0x200 misses (the line was evicted).
- Assert `rst` while in FILL → `mem_req`=0 immediately; an ack pulse after reset is ignored; a read of 0x100 misses.
- Issue `cpu_rd` and `cpu_wr` together to 0x300 → a write transaction is issued (`mem_we`=1) and no fill occurs.

Source files
------------

// File: rtl/dcache_wt.sv
// rtl/dcache_wt.sv - direct-mapped write-through one-word-per-line data cache
// Optional hit/miss counters are compiled in when DCACHE_STATS_EN is defined.
module dcache_wt #(
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_WDONE} state_t;

  state_t               r_state;
  logic [LINES-1:0]     r_valid;
  logic [TAG_W-1:0]     r_tag  [LINES];
  logic [31:0]          r_data [LINES];
  logic                 r_mem_req;
  logic                 r_mem_we;
  logic [31:0]          r_mem_addr;
  logic [31:0]          r_mem_wdata;

  logic [31:0]          w_word_addr;
  logic [IDX_W-1:0]     w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic [IDX_W-1:0]     w_fill_idx;
  logic                 w_hit;
  logic                 w_idle;

  assign w_word_addr = cpu_addr & ~32'h3;
  assign w_idx       = w_word_addr[IDX_W+1:2];
  assign w_tag       = w_word_addr[31:IDX_W+2];
  assign w_fill_idx  = r_mem_addr[IDX_W+1:2];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_idle      = (r_state == S_IDLE);

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // Stall is a function of state, strobes and hit only; mem_ack never feeds it.
  always_comb begin
    cpu_stall = 1'b0;
    case (r_state)
      S_IDLE:  cpu_stall = cpu_wr | (cpu_rd & ~w_hit);
      S_FILL:  cpu_stall = 1'b1;
      S_WRITE: cpu_stall = 1'b1;
      default: cpu_stall = 1'b0;
    endcase
  end

  assign cpu_rdata = (cpu_rd && w_idle && w_hit) ? r_data[w_idx] : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_wr) begin
            r_state     <= S_WRITE;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_word_addr;
            r_mem_wdata <= cpu_wdata;
          end else if (cpu_rd && !w_hit) begin
            r_state    <= S_FILL;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= w_word_addr;
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            r_state              <= S_IDLE;
            r_mem_req            <= 1'b0;
            r_valid[w_fill_idx]  <= 1'b1;
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            r_state   <= S_WDONE;
            r_mem_req <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; validity alone decides whether a line is usable.
  always_ff @(posedge clk) begin
    if (w_idle && cpu_wr && w_hit) begin
      r_data[w_idx] <= cpu_wdata;
    end else if (r_state == S_FILL && mem_ack) begin
      r_data[w_fill_idx] <= mem_rdata;
      r_tag[w_fill_idx]  <= r_mem_addr[31:IDX_W+2];
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= 32'h0;
      miss_cnt <= 32'h0;
    end else begin
      if (w_idle && cpu_rd && !cpu_wr && w_hit) hit_cnt <= hit_cnt + 32'h1;
      if (w_idle && cpu_rd && !cpu_wr && !w_hit) miss_cnt <= miss_cnt + 32'h1;
    end
  end
`endif

endmodule
